// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants for the operand-fetch forwarding/hazard control block.
package fwd_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_DM = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bus between the instruction decoder / register bank and fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW
);
  logic              id_valid;
  logic [REG_AW-1:0] RA;
  logic [REG_AW-1:0] RB;
  logic [REG_AW-1:0] RW;
  logic              use_A;
  logic              use_B;
  logic              use_imm;
  logic              reg_wr;
  logic              is_load;
  logic              flush;

  logic [1:0]        mux_sel_A;
  logic [1:0]        mux_sel_B;
  logic              imm_sel;
  logic              stall;
  logic [REG_AW-1:0] RW_ex;
  logic [REG_AW-1:0] RW_dm;
  logic [REG_AW-1:0] RW_wb;
  logic              wr_wb;

  modport master (
    output id_valid, RA, RB, RW, use_A, use_B, use_imm, reg_wr, is_load, flush,
    input  mux_sel_A, mux_sel_B, imm_sel, stall, RW_ex, RW_dm, RW_wb, wr_wb
  );

  modport slave (
    input  id_valid, RA, RB, RW, use_A, use_B, use_imm, reg_wr, is_load, flush,
    output mux_sel_A, mux_sel_B, imm_sel, stall, RW_ex, RW_dm, RW_wb, wr_wb
  );
endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel_prio.sv
// Per-operand hit detection against EX/DM/WB tags; youngest producer wins.
module fwd_sel_prio #(
  parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
  parameter bit FWD_R0 = 1'b0
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  logic              i_v_ex,
  input  logic              i_wr_ex,
  input  logic [REG_AW-1:0] i_rw_ex,
  input  logic              i_v_dm,
  input  logic              i_wr_dm,
  input  logic [REG_AW-1:0] i_rw_dm,
  input  logic              i_v_wb,
  input  logic              i_wr_wb,
  input  logic [REG_AW-1:0] i_rw_wb,
  output logic [1:0]        o_sel,
  output logic              o_hit_ex
);
  import fwd_hazard_ctrl_pkg::*;

  logic w_fwd_ok;
  logic w_hit_ex;
  logic w_hit_dm;
  logic w_hit_wb;

  // R0 is hardwired zero unless forwarding of it is explicitly enabled
  assign w_fwd_ok = (i_src != '0) | FWD_R0;
  assign w_hit_ex = i_v_ex & i_wr_ex & (i_rw_ex == i_src) & w_fwd_ok;
  assign w_hit_dm = i_v_dm & i_wr_dm & (i_rw_dm == i_src) & w_fwd_ok;
  assign w_hit_wb = i_v_wb & i_wr_wb & (i_rw_wb == i_src) & w_fwd_ok;

  always_comb begin
    o_sel = SEL_RF;
    if (i_use) begin
      if (w_hit_ex)      o_sel = SEL_EX;
      else if (w_hit_dm) o_sel = SEL_DM;
      else if (w_hit_wb) o_sel = SEL_WB;
    end
  end

  assign o_hit_ex = w_hit_ex;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Destination-tag pipeline (EX/DM/WB), operand forwarding select and load-use stall.
module fwd_hazard_ctrl #(
  parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW,
  parameter bit FWD_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_hazard_ctrl_if.slave bus
);
  import fwd_hazard_ctrl_pkg::*;

  logic              r_v_ex, r_wr_ex, r_ld_ex;
  logic              r_v_dm, r_wr_dm, r_ld_dm;
  logic              r_v_wb, r_wr_wb, r_ld_wb;
  logic [REG_AW-1:0] r_rw_ex, r_rw_dm, r_rw_wb;

  logic [1:0]        w_sel_A, w_sel_B;
  logic              w_hit_ex_A, w_hit_ex_B;
  logic              w_stall;
  logic              w_issue;

  fwd_sel_prio #(.REG_AW(REG_AW), .FWD_R0(FWD_R0)) u_sel_a (
    .i_src   (bus.RA),
    .i_use   (bus.use_A),
    .i_v_ex  (r_v_ex), .i_wr_ex (r_wr_ex), .i_rw_ex (r_rw_ex),
    .i_v_dm  (r_v_dm), .i_wr_dm (r_wr_dm), .i_rw_dm (r_rw_dm),
    .i_v_wb  (r_v_wb), .i_wr_wb (r_wr_wb), .i_rw_wb (r_rw_wb),
    .o_sel   (w_sel_A),
    .o_hit_ex(w_hit_ex_A)
  );

  fwd_sel_prio #(.REG_AW(REG_AW), .FWD_R0(FWD_R0)) u_sel_b (
    .i_src   (bus.RB),
    .i_use   (bus.use_B),
    .i_v_ex  (r_v_ex), .i_wr_ex (r_wr_ex), .i_rw_ex (r_rw_ex),
    .i_v_dm  (r_v_dm), .i_wr_dm (r_wr_dm), .i_rw_dm (r_rw_dm),
    .i_v_wb  (r_v_wb), .i_wr_wb (r_wr_wb), .i_rw_wb (r_rw_wb),
    .o_sel   (w_sel_B),
    .o_hit_ex(w_hit_ex_B)
  );

  // Only a load still in EX stalls; from DM onward its result is forwardable
  assign w_stall = bus.id_valid & ~bus.flush & r_ld_ex &
                   ((bus.use_A & w_hit_ex_A) | (bus.use_B & w_hit_ex_B));
  assign w_issue = bus.id_valid & ~w_stall & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_ex  <= 1'b0; r_wr_ex <= 1'b0; r_ld_ex <= 1'b0; r_rw_ex <= '0;
      r_v_dm  <= 1'b0; r_wr_dm <= 1'b0; r_ld_dm <= 1'b0; r_rw_dm <= '0;
      r_v_wb  <= 1'b0; r_wr_wb <= 1'b0; r_ld_wb <= 1'b0; r_rw_wb <= '0;
    end else begin
      r_v_ex  <= w_issue;
      r_wr_ex <= w_issue & bus.reg_wr;
      r_ld_ex <= w_issue & bus.is_load;
      r_rw_ex <= w_issue ? bus.RW : '0;
      r_v_dm  <= r_v_ex;  r_wr_dm <= r_wr_ex; r_ld_dm <= r_ld_ex; r_rw_dm <= r_rw_ex;
      r_v_wb  <= r_v_dm;  r_wr_wb <= r_wr_dm; r_ld_wb <= r_ld_dm; r_rw_wb <= r_rw_dm;
    end
  end

  assign bus.mux_sel_A = w_sel_A;
  assign bus.mux_sel_B = w_sel_B;
  assign bus.imm_sel   = bus.use_imm;
  assign bus.stall     = w_stall;
  assign bus.RW_ex     = r_rw_ex;
  assign bus.RW_dm     = r_rw_dm;
  assign bus.RW_wb     = r_rw_wb;
  assign bus.wr_wb     = r_v_wb & r_wr_wb;

  logic w_unused;
  assign w_unused = r_ld_wb;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: hand-derived expectations queued per decode slot.
module tb_fwd_hazard_ctrl;
  import fwd_hazard_ctrl_pkg::*;

  typedef struct packed {
    logic       idv;
    logic [4:0] ra, rb, rw;
    logic       ua, ub, ui, wr, ld, fl;
    logic [1:0] ea, eb;
    logic       ei, es;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(5)) bus ();

  fwd_hazard_ctrl #(.REG_AW(5), .FWD_R0(1'b0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic vec_t vec(input logic idv, input logic [4:0] ra, rb, rw,
                               input logic ua, ub, ui, wr, ld, fl,
                               input logic [1:0] ea, eb, input logic ei, es);
    vec_t v;
    v.idv = idv; v.ra = ra; v.rb = rb; v.rw = rw;
    v.ua = ua; v.ub = ub; v.ui = ui; v.wr = wr; v.ld = ld; v.fl = fl;
    v.ea = ea; v.eb = eb; v.ei = ei; v.es = es;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.id_valid = v.idv; bus.RA = v.ra; bus.RB = v.rb; bus.RW = v.rw;
    bus.use_A = v.ua; bus.use_B = v.ub; bus.use_imm = v.ui;
    bus.reg_wr = v.wr; bus.is_load = v.ld; bus.flush = v.fl;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    #2;
  endtask

  task automatic drain();
    repeat (3) begin
      @(negedge clk);
      drive(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SEL_RF, SEL_RF, 0, 0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SEL_RF, SEL_RF, 0, 0));
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mux_sel_A, bus.mux_sel_B, bus.stall, bus.wr_wb, bus.RW_ex, bus.RW_dm, bus.RW_wb} !== 21'd0) begin
      failures++;
      $display("FAIL reset_state got selA=%b selB=%b stall=%b wr_wb=%b RW_ex=%0d RW_dm=%0d RW_wb=%0d exp all zero",
               bus.mux_sel_A, bus.mux_sel_B, bus.stall, bus.wr_wb, bus.RW_ex, bus.RW_dm, bus.RW_wb);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    vec_t t[4];
    vec_t e;
    t[0] = vec(1, 0, 0, 7, 0, 0, 0, 1, 0, 0, SEL_RF, SEL_RF, 0, 0);
    t[1] = vec(1, 7, 0, 1, 1, 0, 0, 0, 0, 0, SEL_EX, SEL_RF, 0, 0);
    t[2] = vec(1, 0, 7, 2, 0, 1, 0, 0, 0, 0, SEL_RF, SEL_DM, 0, 0);
    t[3] = vec(1, 7, 0, 3, 1, 0, 0, 0, 0, 0, SEL_WB, SEL_RF, 0, 0);
    drain();
    for (int i = 0; i < 4; i++) begin
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if ({bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall} !== {e.ea, e.eb, e.ei, e.es}) begin
        failures++;
        $display("FAIL b2b[%0d] got selA=%b selB=%b imm=%b stall=%b exp %b %b %b %b", i,
                 bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall, e.ea, e.eb, e.ei, e.es);
      end
    end
    checks++;
    if ({bus.wr_wb, bus.RW_wb} !== {1'b1, 5'd7}) begin
      failures++;
      $display("FAIL b2b_wb_tag got wr_wb=%b RW_wb=%0d exp 1 7", bus.wr_wb, bus.RW_wb);
    end
  endtask

  task automatic test_priority();
    vec_t t[4];
    vec_t e;
    t[0] = vec(1, 0, 0, 5, 0, 0, 0, 1, 0, 0, SEL_RF, SEL_RF, 0, 0);
    t[1] = vec(1, 0, 0, 5, 0, 0, 0, 1, 0, 0, SEL_RF, SEL_RF, 0, 0);
    t[2] = vec(1, 5, 0, 8, 1, 0, 0, 0, 0, 0, SEL_EX, SEL_RF, 0, 0);
    t[3] = vec(1, 0, 5, 9, 0, 1, 0, 0, 0, 0, SEL_RF, SEL_DM, 0, 0);
    drain();
    for (int i = 0; i < 4; i++) begin
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if ({bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall} !== {e.ea, e.eb, e.ei, e.es}) begin
        failures++;
        $display("FAIL prio[%0d] got selA=%b selB=%b imm=%b stall=%b exp %b %b %b %b", i,
                 bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall, e.ea, e.eb, e.ei, e.es);
      end
    end
  endtask

  task automatic test_load_use();
    vec_t t[4];
    vec_t e;
    t[0] = vec(1, 0, 0, 6, 0, 0, 0, 1, 1, 0, SEL_RF, SEL_RF, 0, 0);
    t[1] = vec(1, 0, 6, 6, 0, 1, 0, 1, 0, 0, SEL_RF, SEL_EX, 0, 1);
    t[2] = vec(1, 0, 6, 6, 0, 1, 0, 1, 0, 0, SEL_RF, SEL_DM, 0, 0);
    t[3] = vec(1, 6, 0, 4, 1, 0, 0, 0, 0, 0, SEL_EX, SEL_RF, 0, 0);
    drain();
    for (int i = 0; i < 4; i++) begin
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if ({bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall} !== {e.ea, e.eb, e.ei, e.es}) begin
        failures++;
        $display("FAIL load_use[%0d] got selA=%b selB=%b imm=%b stall=%b exp %b %b %b %b", i,
                 bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall, e.ea, e.eb, e.ei, e.es);
      end
      if (i == 2) begin
        checks++;
        if ({bus.RW_ex, bus.RW_dm} !== {5'd0, 5'd6}) begin
          failures++;
          $display("FAIL load_use_bubble got RW_ex=%0d RW_dm=%0d exp 0 6", bus.RW_ex, bus.RW_dm);
        end
      end
    end
  endtask

  task automatic test_r0_imm();
    vec_t t[5];
    vec_t e;
    t[0] = vec(1, 0, 0, 0,  0, 0, 0, 1, 0, 0, SEL_RF, SEL_RF, 0, 0);
    t[1] = vec(1, 0, 0, 1,  1, 1, 1, 0, 0, 0, SEL_RF, SEL_RF, 1, 0);
    t[2] = vec(1, 0, 0, 2,  0, 1, 1, 0, 0, 0, SEL_RF, SEL_RF, 1, 0);
    t[3] = vec(1, 0, 0, 12, 0, 0, 0, 1, 0, 0, SEL_RF, SEL_RF, 0, 0);
    t[4] = vec(1, 0, 12, 3, 0, 1, 1, 0, 0, 0, SEL_RF, SEL_EX, 1, 0);
    drain();
    for (int i = 0; i < 5; i++) begin
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if ({bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall} !== {e.ea, e.eb, e.ei, e.es}) begin
        failures++;
        $display("FAIL r0_imm[%0d] got selA=%b selB=%b imm=%b stall=%b exp %b %b %b %b", i,
                 bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall, e.ea, e.eb, e.ei, e.es);
      end
    end
  endtask

  task automatic test_flush_vs_stall();
    vec_t t[5];
    vec_t e;
    t[0] = vec(1, 0, 0, 4, 0, 0, 0, 1, 1, 0, SEL_RF, SEL_RF, 0, 0);
    t[1] = vec(0, 4, 0, 0, 1, 0, 0, 0, 0, 0, SEL_EX, SEL_RF, 0, 0);
    t[2] = vec(1, 0, 0, 3, 0, 0, 0, 1, 1, 0, SEL_RF, SEL_RF, 0, 0);
    t[3] = vec(1, 3, 0, 3, 1, 0, 0, 1, 0, 1, SEL_EX, SEL_RF, 0, 0);
    t[4] = vec(1, 3, 0, 5, 1, 0, 0, 0, 0, 0, SEL_DM, SEL_RF, 0, 0);
    drain();
    for (int i = 0; i < 5; i++) begin
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if ({bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall} !== {e.ea, e.eb, e.ei, e.es}) begin
        failures++;
        $display("FAIL flush[%0d] got selA=%b selB=%b imm=%b stall=%b exp %b %b %b %b", i,
                 bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall, e.ea, e.eb, e.ei, e.es);
      end
    end
  endtask

  task automatic test_reset_midrun();
    vec_t t[5];
    vec_t e;
    t[0] = vec(1, 0, 0, 11, 0, 0, 0, 1, 0, 0, SEL_RF, SEL_RF, 0, 0);
    t[1] = vec(1, 0, 0, 13, 0, 0, 0, 1, 0, 0, SEL_RF, SEL_RF, 0, 0);
    t[2] = vec(1, 0, 0, 9,  0, 0, 0, 1, 1, 0, SEL_RF, SEL_RF, 0, 0);
    t[3] = vec(1, 9, 0, 1,  1, 0, 0, 0, 0, 0, SEL_EX, SEL_RF, 0, 1);
    t[4] = vec(1, 9, 13, 1, 1, 1, 0, 0, 0, 0, SEL_RF, SEL_RF, 0, 0);
    drain();
    for (int i = 0; i < 4; i++) begin
      apply(t[i]);
      e = sb.pop_front();
      checks++;
      if ({bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall} !== {e.ea, e.eb, e.ei, e.es}) begin
        failures++;
        $display("FAIL midrun[%0d] got selA=%b selB=%b imm=%b stall=%b exp %b %b %b %b", i,
                 bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall, e.ea, e.eb, e.ei, e.es);
      end
    end
    checks++;
    if ({bus.wr_wb, bus.RW_wb, bus.RW_dm, bus.RW_ex} !== {1'b1, 5'd11, 5'd13, 5'd9}) begin
      failures++;
      $display("FAIL midrun_pre_tags got wr_wb=%b RW_wb=%0d RW_dm=%0d RW_ex=%0d exp 1 11 13 9",
               bus.wr_wb, bus.RW_wb, bus.RW_dm, bus.RW_ex);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mux_sel_A, bus.mux_sel_B, bus.stall, bus.wr_wb, bus.RW_ex, bus.RW_dm, bus.RW_wb} !== 21'd0) begin
      failures++;
      $display("FAIL midrun_async_reset got selA=%b selB=%b stall=%b wr_wb=%b RW_ex=%0d RW_dm=%0d RW_wb=%0d exp all zero",
               bus.mux_sel_A, bus.mux_sel_B, bus.stall, bus.wr_wb, bus.RW_ex, bus.RW_dm, bus.RW_wb);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(t[4]);
    e = sb.pop_front();
    checks++;
    if ({bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall} !== {e.ea, e.eb, e.ei, e.es}) begin
      failures++;
      $display("FAIL midrun_post got selA=%b selB=%b imm=%b stall=%b exp %b %b %b %b",
               bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall, e.ea, e.eb, e.ei, e.es);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_priority();
    test_load_use();
    test_r0_imm();
    test_flush_vs_stall();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
